// File: rtl/can_rx_destuffer_if.sv
// Bundle between the bit-timing/frame-decoder side (master) and the CAN rx destuffer (slave).
// The master drives the sample strobe, the rx line and the restart request.
interface can_rx_destuffer_if #(
    parameter int WIDTH = 100
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             sample_en;
    logic             rx;
    logic             clear;
    logic [WIDTH-1:0] shifted_bus;
    logic [CW-1:0]    bit_count;
    logic             bus_idle;
    logic             frame_active;
    logic             full;
    logic             stuff_err;

    modport master (
        output sample_en, rx, clear,
        input  shifted_bus, bit_count, bus_idle, frame_active, full, stuff_err
    );

    modport slave (
        input  sample_en, rx, clear,
        output shifted_bus, bit_count, bus_idle, frame_active, full, stuff_err
    );
endinterface

// File: rtl/can_rx_destuffer.sv
// CAN receive destuffer: waits for bus idle, detects SOF, drops stuff bits, flags stuff
// violations and shifts destuffed bits into a WIDTH-bit register with a valid-bit count.
module can_rx_destuffer #(
    parameter int WIDTH     = 100,
    parameter int STUFF_LEN = 5,
    parameter int IDLE_BITS = 11
) (
    input  logic                baud_clk,
    input  logic                rst,
    can_rx_destuffer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(IDLE_BITS + 1);
    localparam int RW = $clog2(STUFF_LEN + 1);

    localparam logic [CW-1:0] LAST_BIT_C  = CW'(WIDTH - 1);
    localparam logic [IW-1:0] IDLE_LAST_C = IW'(IDLE_BITS - 1);
    localparam logic [RW-1:0] STUFF_C     = RW'(STUFF_LEN);

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_RECEIVE   = 3'd2,
        ST_DONE      = 3'd3,
        ST_ERROR     = 3'd4
    } state_e;

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] shift_q,    shift_d;
    logic [CW-1:0]    count_q,    count_d;
    logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
    logic [RW-1:0]    run_q,      run_d;
    logic             last_q,     last_d;
    logic             idle_q,     idle_d;
    logic             active_q,   active_d;
    logic             full_q,     full_d;
    logic             err_q,      err_d;

    // State and datapath registers; async reset puts the block back to waiting for idle.
    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_WAIT_IDLE;
            shift_q    <= '0;
            count_q    <= '0;
            idle_cnt_q <= '0;
            run_q      <= '0;
            last_q     <= 1'b1;
            idle_q     <= 1'b0;
            active_q   <= 1'b0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            idle_cnt_q <= idle_cnt_d;
            run_q      <= run_d;
            last_q     <= last_d;
            idle_q     <= idle_d;
            active_q   <= active_d;
            full_q     <= full_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic: clear wins over a coincident sample; nothing moves without sample_en.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        count_d    = count_q;
        idle_cnt_d = idle_cnt_q;
        run_d      = run_q;
        last_d     = last_q;
        idle_d     = idle_q;
        active_d   = active_q;
        full_d     = full_q;
        err_d      = err_q;

        if (bus.clear) begin
            state_d    = ST_WAIT_IDLE;
            shift_d    = '0;
            count_d    = '0;
            idle_cnt_d = '0;
            run_d      = '0;
            last_d     = 1'b1;
            idle_d     = 1'b0;
            active_d   = 1'b0;
            full_d     = 1'b0;
            err_d      = 1'b0;
        end else if (bus.sample_en) begin
            case (state_q)
                ST_WAIT_IDLE: begin
                    if (!bus.rx) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == IDLE_LAST_C) begin
                        idle_cnt_d = idle_cnt_q + IW'(1);
                        state_d    = ST_IDLE;
                        idle_d     = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IW'(1);
                    end
                end
                ST_IDLE: begin
                    if (!bus.rx) begin
                        shift_d  = {shift_q[WIDTH-2:0], 1'b0};
                        count_d  = CW'(1);
                        run_d    = RW'(1);
                        last_d   = 1'b0;
                        state_d  = ST_RECEIVE;
                        idle_d   = 1'b0;
                        active_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RECEIVE: begin
                    if (run_q == STUFF_C) begin
                        // Stuff position: an opposite bit is dropped, an equal one is a violation.
                        if (bus.rx != last_q) begin
                            run_d  = RW'(1);
                            last_d = bus.rx;
                        end else begin
                            err_d    = 1'b1;
                            active_d = 1'b0;
                            state_d  = ST_ERROR;
                        end
                    end else begin
                        shift_d = {shift_q[WIDTH-2:0], bus.rx};
                        count_d = count_q + CW'(1);
                        if (bus.rx == last_q) begin
                            run_d = run_q + RW'(1);
                        end else begin
                            run_d  = RW'(1);
                            last_d = bus.rx;
                        end
                        if (count_q == LAST_BIT_C) begin
                            full_d   = 1'b1;
                            active_d = 1'b0;
                            state_d  = ST_DONE;
                        end else begin
                            state_d = ST_RECEIVE;
                        end
                    end
                end
                ST_DONE:  state_d = ST_DONE;
                ST_ERROR: state_d = ST_ERROR;
                default: begin
                    state_d  = ST_WAIT_IDLE;
                    idle_d   = 1'b0;
                    active_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign bus.shifted_bus  = shift_q;
    assign bus.bit_count    = count_q;
    assign bus.bus_idle     = idle_q;
    assign bus.frame_active = active_q;
    assign bus.full         = full_q;
    assign bus.stuff_err    = err_q;

endmodule

// File: tb/tb_can_rx_destuffer.sv
// Directed table-driven bench for can_rx_destuffer with WIDTH=8, STUFF_LEN=5, IDLE_BITS=11.
module tb_can_rx_destuffer;

    logic baud_clk = 1'b0;
    logic rst_n    = 1'b0;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    can_rx_destuffer_if #(.WIDTH(8)) bus_if ();

    can_rx_destuffer #(.WIDTH(8), .STUFF_LEN(5), .IDLE_BITS(11)) dut (
        .baud_clk (baud_clk),
        .rst      (rst_n),
        .bus      (bus_if)
    );

    always #5 baud_clk = ~baud_clk;

    typedef struct {
        logic        se;
        logic        rx;
        logic        clr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Expected output word: {shifted_bus, bit_count, bus_idle, frame_active, full, stuff_err}
    function automatic logic [15:0] ex(input logic [7:0] b, input logic [3:0] c,
                                       input logic i, input logic a, input logic f, input logic e);
        return {b, c, i, a, f, e};
    endfunction

    function automatic logic [15:0] actual();
        return {bus_if.shifted_bus, bus_if.bit_count, bus_if.bus_idle,
                bus_if.frame_active, bus_if.full, bus_if.stuff_err};
    endfunction

    task automatic add(input logic se, input logic rx, input logic clr,
                       input logic [15:0] e, input int n = 1);
        vec_t v;
        v.se = se; v.rx = rx; v.clr = clr; v.exp = e;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] e);
        logic [15:0] a;
        a = actual();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got bus=%h cnt=%0d idle=%b act=%b full=%b err=%b, expected bus=%h cnt=%0d idle=%b act=%b full=%b err=%b",
                     name, a[15:8], a[7:4], a[3], a[2], a[1], a[0],
                     e[15:8], e[7:4], e[3], e[2], e[1], e[0]);
        end
    endtask

    task automatic step(input logic se, input logic rx, input logic clr);
        @(negedge baud_clk);
        bus_if.sample_en = se;
        bus_if.rx        = rx;
        bus_if.clear     = clr;
        @(posedge baud_clk);
        #1;
    endtask

    task automatic restart();
        add(1'b1, 1'b0, 1'b1, ex(8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(1'b1, 1'b1, 1'b0, ex(8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), 10);
        add(1'b1, 1'b1, 1'b0, ex(8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        logic [15:0] idl0, idl1, done2, done_b, err4;
        idl0   = ex(8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idl1   = ex(8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        done2  = ex(8'h59, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);
        done_b = ex(8'h5F, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);
        err4   = ex(8'h00, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);

        // Idle detection with a dominant sample restarting the count
        add(1'b1, 1'b1, 1'b0, idl0, 10);
        add(1'b1, 1'b0, 1'b0, idl0);
        add(1'b1, 1'b1, 1'b0, idl0, 10);
        add(1'b1, 1'b1, 1'b0, idl1, 2);

        // Plain frame 0,1,0,1,1,0,0,1
        add(1'b1, 1'b0, 1'b0, ex(8'h00, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b1, 1'b0, ex(8'h01, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b0, 1'b0, ex(8'h02, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b1, 1'b0, ex(8'h05, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b1, 1'b0, ex(8'h0B, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b0, 1'b0, ex(8'h16, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b0, 1'b0, ex(8'h2C, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b1, 1'b0, done2);
        add(1'b1, 1'b0, 1'b0, done2, 3);
        add(1'b1, 1'b1, 1'b0, done2, 2);
        restart();

        // Destuff: the 1 after five 0s is dropped
        add(1'b1, 1'b0, 1'b0, ex(8'h00, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b0, 1'b0, ex(8'h00, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b0, 1'b0, ex(8'h00, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b0, 1'b0, ex(8'h00, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b0, 1'b0, ex(8'h00, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b1, 1'b0, ex(8'h00, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b0, 1'b0, ex(8'h00, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b1, 1'b0, ex(8'h01, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b1, 1'b0, ex(8'h03, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0));
        add(1'b1, 1'b1, 1'b0, ex(8'h03, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0), 2);
        restart();

        // Run of five 1s ends exactly on the last data bit: the next equal bit is not examined
        add(1'b1, 1'b0, 1'b0, ex(8'h00, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b1, 1'b0, ex(8'h01, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b0, 1'b0, ex(8'h02, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b1, 1'b0, ex(8'h05, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b1, 1'b0, ex(8'h0B, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b1, 1'b0, ex(8'h17, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b1, 1'b0, ex(8'h2F, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b1, 1'b0, done_b);
        add(1'b1, 1'b1, 1'b0, done_b);
        add(1'b1, 1'b0, 1'b0, done_b);
        restart();

        // Stuff error on the sixth dominant bit, held for 20 samples
        for (int k = 1; k <= 5; k++)
            add(1'b1, 1'b0, 1'b0, ex(8'h00, 4'(k), 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b0, 1'b0, err4);
        for (int k = 0; k < 20; k++)
            add(1'b1, 1'(k % 2), 1'b0, err4);
        restart();

        // Gating: rx toggles with sample_en low, then clear with a coincident sample
        add(1'b1, 1'b0, 1'b0, ex(8'h00, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b1, 1'b0, ex(8'h01, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b1, 1'b0, ex(8'h03, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 10; k++)
            add(1'b0, 1'(k % 2), 1'b0, ex(8'h03, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b1, 1'b0, 1'b1, idl0);
        add(1'b1, 1'b0, 1'b0, idl0);
        add(1'b1, 1'b1, 1'b0, idl0, 10);
        add(1'b1, 1'b1, 1'b0, idl1);
        add(1'b1, 1'b0, 1'b0, ex(8'h00, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0));

        bus_if.sample_en = 1'b0;
        bus_if.rx        = 1'b1;
        bus_if.clear     = 1'b0;
        repeat (2) @(posedge baud_clk);
        #1;
        check("reset_state", idl0);
        @(negedge baud_clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].se, vecs[i].rx, vecs[i].clr);
            check($sformatf("vec[%0d]", i), vecs[i].exp);
        end

        // Async reset in the middle of a frame, away from any clock edge
        step(1'b1, 1'b1, 1'b0);
        check("pre_rst_frame", ex(8'h01, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0));
        bus_if.sample_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", idl0);
        #4;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 1'b0);
            check($sformatf("post_rst_idle[%0d]", k), idl0);
        end
        step(1'b1, 1'b1, 1'b0);
        check("post_rst_idle_up", idl1);
        step(1'b1, 1'b0, 1'b0);
        check("post_rst_sof", ex(8'h00, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/can_rx_destuffer.md
Name: can_rx_destuffer

Overview:
Parametrised successor to the receive bit shift register. It samples the CAN rx line once per bit time under a sample strobe, waits for bus idle, and detects start-of-frame. It removes stuff bits and flags stuff errors, then shifts the destuffed bits into a WIDTH-bit register with a valid-bit count. It sits between the bit-timing/sample-point logic and the frame decoder, which reads shifted_bus and bit_count and restarts the block with clear.

Parameters:
WIDTH, 100, length of destuffed shift register in bits (>= 2)
STUFF_LEN, 5, number of equal consecutive bits after which the next bit is a stuff bit
IDLE_BITS, 11, consecutive recessive samples required to declare bus idle
CW (localparam), clog2(WIDTH+1), width of bit_count

Ports:
baud_clk  input  1  block clock; all registers update on rising edge
rst  input  1  asynchronous, active-low reset
sample_en  input  1  one-cycle strobe at the bit sample point; block advances only when high
rx  input  1  CAN receive line, already synchronised; 1 = recessive, 0 = dominant
clear  input  1  synchronous restart from frame decoder
shifted_bus  output  WIDTH  destuffed bits, newest bit in [0], oldest toward [WIDTH-1]
bit_count  output  CW  number of destuffed bits shifted in since SOF (SOF included)
bus_idle  output  1  high in IDLE state
frame_active  output  1  high in RECEIVE state
full  output  1  bit_count == WIDTH; register frozen
stuff_err  output  1  stuff violation detected; sticky until clear/reset

Behaviour:
- Reset (rst low, async): shifted_bus=0, bit_count=0, all flags 0, idle counter=0, run_len=0, last_bit=1, state=WAIT_IDLE.
- All outputs are registered. They change only on a baud_clk edge with sample_en=1, or with clear=1.
- clear=1: same values as reset, applied on the edge. It has priority over sample_en; a coincident sample is discarded.
- States: WAIT_IDLE, IDLE, RECEIVE, DONE, ERROR.
- WAIT_IDLE: on a sample with rx=1, idle counter increments; rx=0 zeroes it. When the counter reaches IDLE_BITS (on the IDLE_BITS-th consecutive recessive sample) -> IDLE, bus_idle=1.
- IDLE: rx=1 holds. rx=0 is SOF:
  - shifted_bus={shifted_bus[WIDTH-2:0],0}, bit_count=1, run_len=1, last_bit=0
  - state -> RECEIVE, bus_idle=0, frame_active=1
- RECEIVE, on each sample:
  - Stuff position (run_len==STUFF_LEN):
    - rx != last_bit: bit discarded (no shift, bit_count unchanged), run_len=1, last_bit=rx.
    - rx == last_bit: stuff_err=1, frame_active=0 -> ERROR. shifted_bus and bit_count are held.
  - Otherwise: shift rx in at [0] and increment bit_count. If rx==last_bit, run_len++; else run_len=1 and last_bit=rx.
  - When bit_count becomes WIDTH: full=1, frame_active=0 -> DONE.
- A stuff bit following the WIDTH-th data bit is not examined; DONE is entered immediately.
- DONE and ERROR ignore samples and hold all outputs until clear or reset.
- Destuffing applies to every bit after SOF. The frame decoder issues clear at the end of the stuffed region and before the CRC delimiter/ACK/EOF.
- Reset or clear mid-frame abandons the frame. The block must re-detect IDLE_BITS recessive samples before accepting a new SOF.
- rx changes while sample_en=0 have no effect.

Test Plan:
Use WIDTH=8, STUFF_LEN=5, IDLE_BITS=11 throughout.
1. Idle detect: 10 samples rx=1, 1 sample rx=0, then 11 samples rx=1 -> bus_idle stays 0 until the 11th consecutive 1, then bus_idle=1. A dominant sample before that point restarts the count.
2. Plain frame: from IDLE, sample 0,1,0,1,1,0,0,1 -> shifted_bus=8'b01011001, bit_count=8, full=1, frame_active=0. Further samples leave the outputs unchanged.
3. Destuff: from IDLE, sample 0,0,0,0,0,1,0,1,1 -> the 1 after five 0s is dropped; shifted_bus=8'b00000011, bit_count=8, full=1, stuff_err=0.
4. Stuff error: from IDLE, sample 0 six times -> stuff_err=1 on the 6th sample, bit_count=5, shifted_bus=8'b00000000. The state is held through 20 more samples.
5. Gating and clear: in RECEIVE after 3 bits, toggle rx with sample_en=0 for 10 cycles -> no change. Then assert clear together with sample_en -> all outputs 0, and 11 recessive samples are needed before a new SOF is accepted.
6. Async reset: drive rst low mid-cycle during RECEIVE -> outputs go to 0 immediately without a clock edge; after release, bus_idle rises only after 11 recessive samples.
